// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - fwd_sel_e   : operand forwarding mux select (none / writeback / memory)
//   - RESULT_SRC_LOAD : ResultSrc encoding that marks a load in Execute
//   - mdu_state_e : state of the one-entry MDU scoreboard
package pipeline_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_scoreboard.sv
// mdu_scoreboard
//   One-entry scoreboard for the multi-cycle multiply/divide unit. It records
//   the destination register of the in-flight MDU operation and runs a
//   watchdog that abandons the entry if the MDU never reports completion.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   MduStartE   : Execute issues an MDU op whose destination is RdE
//   RdE         : Execute destination register
//   DMemStallM  : pipeline frozen; an issue in this cycle is not accepted
//   MduDone     : MDU result is written back this cycle
//   MduBusy     : entry occupied (registered)
//   MduPendRd   : destination of the pending op, 0 when idle (registered)
//   MduTimeout  : sticky watchdog error, cleared only by rst (registered)
module mdu_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = $clog2(MDU_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MduStartE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  DMemStallM,
  input  logic                  MduDone,
  output logic                  MduBusy,
  output logic [REG_ADDR_W-1:0] MduPendRd,
  output logic                  MduTimeout
);

  // Counter value seen in the last permitted BUSY cycle; the entry is
  // therefore held for exactly MDU_TIMEOUT cycles before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  mdu_state_e            state_q;
  logic [REG_ADDR_W-1:0] pend_rd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A frozen pipeline re-presents the same issue next cycle, so it
          // must not be latched now or it would be counted twice.
          if (MduStartE && !DMemStallM) begin
            state_q   <= BUSY;
            pend_rd_q <= RdE;
            cnt_q     <= '0;
          end
        end
        BUSY: begin
          // Completion is honoured even during a memory freeze: the MDU
          // writes the register file independently of the pipeline.
          if (MduDone) begin
            state_q   <= IDLE;
            pend_rd_q <= '0;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
            pend_rd_q <= '0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          pend_rd_q <= '0;
          cnt_q     <= '0;
        end
      endcase
    end
  end

  assign MduBusy    = (state_q == BUSY);
  assign MduPendRd  = pend_rd_q;
  assign MduTimeout = timeout_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard controller for the 5-stage core. Produces the Execute operand
//   forwarding selects and the stall/flush enables of the pipeline registers,
//   covering load-use, MDU issue/pending hazards, taken branches and data
//   memory back-pressure. The MDU scoreboard state lives in mdu_scoreboard.
// Ports:
//   Rs1D/Rs2D/RdD, RegWriteD, MduOpD        : Decode-stage instruction
//   Rs1E/Rs2E/RdE, ResultSrcE, MduStartE    : Execute-stage instruction
//   PCSrcE                                  : taken branch/jump in Execute
//   RdM/RegWriteM, RdW/RegWriteW            : later-stage writers
//   DMemStallM                              : data memory not ready
//   MduDone                                 : MDU writeback this cycle
//   ForwardAE/ForwardBE                     : 00 none, 01 from W, 10 from M
//   StallF/D/E/M, FlushD/E/W                : pipeline register controls
//   MduBusy/MduPendRd/MduTimeout            : scoreboard status (registered)
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = $clog2(MDU_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic                  MduOpD,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MduStartE,
  input  logic                  PCSrcE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  DMemStallM,
  input  logic                  MduDone,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  MduBusy,
  output logic [REG_ADDR_W-1:0] MduPendRd,
  output logic                  MduTimeout
);

  // Memory stage has the younger result, so it wins over writeback.
  // x0 is hard-wired zero and is never forwarded.
  function automatic fwd_sel_e fwd_pick(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    fwd_sel_e sel;
    sel = FWD_NONE;
    if (rs != '0) begin
      if (we_m && (rs == rd_m))      sel = FWD_MEM;
      else if (we_w && (rs == rd_w)) sel = FWD_WB;
    end
    return sel;
  endfunction

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  assign fwd_a     = fwd_pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign fwd_b     = fwd_pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  logic load_stall;
  logic mdu_issue_stall;
  logic mdu_stall;
  logic data_stall;
  logic pend_hit;

  assign load_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

  // The issuing MDU op will hold its destination for several cycles, so a
  // following writer of the same register (WAW) must also wait.
  assign mdu_issue_stall = MduStartE && (RdE != '0) &&
                           ((Rs1D == RdE) || (Rs2D == RdE) ||
                            (RegWriteD && (RdD == RdE)));

  assign pend_hit = (MduPendRd != '0) &&
                    ((Rs1D == MduPendRd) || (Rs2D == MduPendRd) ||
                     (RegWriteD && (RdD == MduPendRd)));

  // Any MDU op in Decode while the single entry is occupied is a
  // structural hazard.
  assign mdu_stall  = MduBusy && (MduOpD || pend_hit);
  assign data_stall = load_stall || mdu_issue_stall || mdu_stall;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (DMemStallM) begin
      // Freeze everything up to Memory; the instruction leaving Memory is
      // replayed, so Writeback receives a bubble. A branch in Execute stays
      // put and is resolved again once memory is ready.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // The stalled Decode instruction is on the wrong path anyway.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (data_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  mdu_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .MDU_TIMEOUT(MDU_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mdu_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .MduStartE (MduStartE),
    .RdE       (RdE),
    .DMemStallM(DMemStallM),
    .MduDone   (MduDone),
    .MduBusy   (MduBusy),
    .MduPendRd (MduPendRd),
    .MduTimeout(MduTimeout)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteD, MduOpD, MduStartE, PCSrcE;
  logic          RegWriteM, RegWriteW, DMemStallM, MduDone;
  logic [1:0]    ResultSrcE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic          MduBusy, MduTimeout;
  logic [RW-1:0] MduPendRd;

  hazard_scoreboard #(.REG_ADDR_W(RW), .MDU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .MduOpD(MduOpD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .MduStartE(MduStartE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .DMemStallM(DMemStallM), .MduDone(MduDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MduBusy(MduBusy), .MduPendRd(MduPendRd), .MduTimeout(MduTimeout)
  );

  always #5 clk = ~clk;

  // Packed response: {FwdA, FwdB, StallF/D/E/M, FlushD/E/W, Busy, PendRd, Timeout}
  typedef struct {
    string       nm;
    logic [17:0] v;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_DATA = 4'b1100;
  localparam logic [3:0] S_ALL  = 4'b1111;
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_E    = 3'b010;
  localparam logic [2:0] F_BR   = 3'b110;
  localparam logic [2:0] F_W    = 3'b001;

  // Monitor: every cycle that has an expectation outstanding, compare the
  // outputs at the falling edge (mid-cycle, away from the active edge).
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [17:0] act;
      e   = q.pop_front();
      act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MduBusy, MduPendRd, MduTimeout};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b busy=%b pend=%0d tout=%b, expected fa=%b fb=%b st=%b fl=%b busy=%b pend=%0d tout=%b",
                 e.nm, act[17:16], act[15:14], act[13:10], act[9:7], act[6], act[5:1], act[0],
                 e.v[17:16], e.v[15:14], e.v[13:10], e.v[9:7], e.v[6], e.v[5:1], e.v[0]);
      end else begin
        $display("ok   %s: fa=%b fb=%b st=%b fl=%b busy=%b pend=%0d tout=%b",
                 e.nm, act[17:16], act[15:14], act[13:10], act[9:7], act[6], act[5:1], act[0]);
      end
    end
  end

  task automatic clr();
    rst = 1'b0;
    Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; MduOpD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = 2'b00;
    MduStartE = 1'b0; PCSrcE = 1'b0;
    RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    DMemStallM = 1'b0; MduDone = 1'b0;
  endtask

  // Queue the expectation for the inputs currently applied, then advance
  // one cycle. Called just after a rising edge.
  task automatic step(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] st, input logic [2:0] fl, input logic busy,
                      input logic [RW-1:0] pend, input logic tout);
    exp_t e;
    e.nm = nm;
    e.v  = {fa, fb, st, fl, busy, pend, tout};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("reset", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    rst = 1'b0;
    step("post_reset", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // Forwarding
    clr(); RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5;
    step("fwd_mem", 2'b10, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    RegWriteM = 0;
    step("fwd_wb", 2'b01, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr(); RegWriteM = 1; RegWriteW = 1;
    step("fwd_x0", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr(); Rs1E = 4; Rs2E = 9; RdM = 9; RdW = 4; RegWriteM = 1; RegWriteW = 1;
    step("fwd_b_mem_a_wb", 2'b01, 2'b10, S_NONE, F_NONE, 0, 0, 0);

    // Load-use
    clr(); ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    step("load_use", 2'b00, 2'b00, S_DATA, F_E, 0, 0, 0);
    clr(); ResultSrcE = 2'b01;
    step("load_rd0", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr(); ResultSrcE = 2'b10; RdE = 3; Rs2D = 3;
    step("not_load", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // MDU RAW
    clr(); MduStartE = 1; RdE = 7; Rs1D = 7;
    step("mdu_issue_raw", 2'b00, 2'b00, S_DATA, F_E, 0, 0, 0);
    clr(); Rs1D = 7;
    step("mdu_raw_1", 2'b00, 2'b00, S_DATA, F_E, 1, 7, 0);
    step("mdu_raw_2", 2'b00, 2'b00, S_DATA, F_E, 1, 7, 0);
    MduDone = 1;
    step("mdu_done", 2'b00, 2'b00, S_DATA, F_E, 1, 7, 0);
    MduDone = 0;
    step("mdu_release", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // MDU WAW at issue, structural and pending hazards
    clr(); MduStartE = 1; RdE = 12; RdD = 12; RegWriteD = 1;
    step("mdu_issue_waw", 2'b00, 2'b00, S_DATA, F_E, 0, 0, 0);
    clr(); MduOpD = 1; Rs1D = 1; Rs2D = 2; RdD = 3; RegWriteD = 1;
    step("mdu_struct", 2'b00, 2'b00, S_DATA, F_E, 1, 12, 0);
    clr(); RdD = 12; RegWriteD = 1;
    step("mdu_waw", 2'b00, 2'b00, S_DATA, F_E, 1, 12, 0);
    RegWriteD = 0;
    step("mdu_rd_nowrite", 2'b00, 2'b00, S_NONE, F_NONE, 1, 12, 0);
    clr(); Rs2D = 12;
    step("mdu_rs2", 2'b00, 2'b00, S_DATA, F_E, 1, 12, 0);
    clr(); MduDone = 1;
    step("mdu_done2", 2'b00, 2'b00, S_NONE, F_NONE, 1, 12, 0);
    clr(); MduDone = 1;
    step("done_while_idle", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr();
    step("idle_after_done", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // Branch beats data stall
    clr(); PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    step("branch_vs_load", 2'b00, 2'b00, S_NONE, F_BR, 0, 0, 0);

    // Memory freeze beats branch, stall and MDU issue
    clr(); DMemStallM = 1; PCSrcE = 1; MduStartE = 1; RdE = 8; ResultSrcE = 2'b01; Rs1D = 8;
    step("mem_freeze", 2'b00, 2'b00, S_ALL, F_W, 0, 0, 0);
    clr();
    step("freeze_no_issue", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // MduDone during a memory freeze still clears the entry
    clr(); MduStartE = 1; RdE = 11;
    step("mdu_issue_11", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr(); DMemStallM = 1; MduDone = 1;
    step("done_in_freeze", 2'b00, 2'b00, S_ALL, F_W, 1, 11, 0);
    clr();
    step("cleared_in_freeze", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // Watchdog: busy for exactly TO cycles, then sticky timeout
    clr(); MduStartE = 1; RdE = 9;
    step("wd_start", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);
    clr();
    for (int i = 0; i < TO; i++) begin
      step($sformatf("wd_busy_%0d", i), 2'b00, 2'b00, S_NONE, F_NONE, 1, 9, 0);
    end
    step("wd_fire", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 1);
    MduStartE = 1; RdE = 10;
    step("wd_sticky_issue", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 1);
    clr();
    step("wd_sticky_busy", 2'b00, 2'b00, S_NONE, F_NONE, 1, 10, 1);

    // Reset mid-busy abandons the entry and clears the timeout
    rst = 1;
    step("rst_mid_busy", 2'b00, 2'b00, S_NONE, F_NONE, 1, 10, 1);
    rst = 0;
    step("after_rst", 2'b00, 2'b00, S_NONE, F_NONE, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
